// File: rtl/draw_scheduler.sv
// ---------------------------------------------------------------------------------------------
// draw_scheduler
//
// Time-multiplexes one VGA pixel-write port between four drawing clients. Each frame_tick
// starts a pass that visits the enabled clients in fixed order 0,1,2,3. The current client is
// granted through cl_draw and its pixel fields are muxed onto vga_x/vga_y/vga_colour. A
// per-client watchdog forces release if the client never reports done.
//
// Ports
//   clk            system clock, all logic on the rising edge
//   reset          synchronous, active-low reset
//   space_pressed  synchronous abort back to idle (game restart)
//   frame_tick     one-cycle pulse that starts a pass when idle
//   enable_mask    per-client enable, captured when a tick is accepted
//   err_clr        clears the sticky error flags
//   cl_done        per-client done flags (bit i = client i)
//   cl_x/cl_y/cl_colour  packed client pixel buses (8/7/3 bits per client)
//   cl_draw        one-hot grant, high only while a client is active
//   vga_x/vga_y/vga_colour  muxed pixel, zero when no client is active
//   plot           VGA write enable
//   busy           pass in progress (includes the cycle a tick is accepted)
//   frame_done     one-cycle pulse at the end of a pass
//   timeout_err    sticky, a client was released by the watchdog
//   overrun_err    sticky, a tick arrived while a pass was running
//
// TIMEOUT must be representable in WD_W bits.
// ---------------------------------------------------------------------------------------------
module draw_scheduler #(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned WD_W    = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        space_pressed,
   input  logic        frame_tick,
   input  logic [3:0]  enable_mask,
   input  logic        err_clr,
   input  logic [3:0]  cl_done,
   input  logic [31:0] cl_x,
   input  logic [27:0] cl_y,
   input  logic [11:0] cl_colour,
   output logic [3:0]  cl_draw,
   output logic [7:0]  vga_x,
   output logic [6:0]  vga_y,
   output logic [2:0]  vga_colour,
   output logic        plot,
   output logic        busy,
   output logic        frame_done,
   output logic        timeout_err,
   output logic        overrun_err
);

   localparam logic [WD_W-1:0] WdMax = WD_W'(TIMEOUT);

   typedef enum logic [2:0] {
      StIdle,
      StSelect,
      StActive,
      StRelease,
      StFinish
   } state_e;

   state_e            state_q, state_d;
   logic [1:0]        idx_q, idx_d;
   logic [WD_W-1:0]   wd_q, wd_d;
   logic [3:0]        mask_q, mask_d;
   logic              timeout_err_q, timeout_err_d;
   logic              overrun_err_q, overrun_err_d;

   logic              active;
   logic              wd_nz;
   logic              wd_expired;
   logic              done_valid;
   logic              timeout_hit;
   logic              overrun_hit;

   assign active     = (state_q == StActive);
   assign wd_nz      = (wd_q != '0);
   assign wd_expired = (wd_q == WdMax);
   // A done flag seen on the grant-entry cycle is left over from the previous pass.
   assign done_valid = cl_done[idx_q] && wd_nz;

   // ------------------------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      wd_d        = wd_q;
      mask_d      = mask_q;
      timeout_hit = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (frame_tick) begin
               mask_d  = enable_mask;
               idx_d   = 2'd0;
               wd_d    = '0;
               state_d = StSelect;
            end
         end

         StSelect: begin
            if (mask_q[idx_q]) begin
               wd_d    = '0;
               state_d = StActive;
            end else if (idx_q == 2'd3) begin
               state_d = StFinish;
            end else begin
               idx_d = idx_q + 2'd1;
            end
         end

         StActive: begin
            if (!wd_expired) begin
               wd_d = wd_q + 1'b1;
            end
            // Done beats the watchdog when both land on the same cycle.
            if (done_valid) begin
               state_d = StRelease;
            end else if (wd_expired) begin
               timeout_hit = 1'b1;
               state_d     = StRelease;
            end
         end

         StRelease: begin
            if (idx_q == 2'd3) begin
               state_d = StFinish;
            end else begin
               idx_d   = idx_q + 2'd1;
               state_d = StSelect;
            end
         end

         StFinish: begin
            idx_d   = 2'd0;
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase

      // Abort drops the pass silently; mask and sticky flags are left alone.
      if (space_pressed) begin
         state_d = StIdle;
         idx_d   = 2'd0;
         wd_d    = '0;
      end
   end

   // ------------------------------------------------------------------------------------------
   // Sticky error flags: a set event outranks a clear in the same cycle.
   // ------------------------------------------------------------------------------------------
   assign overrun_hit = frame_tick && (state_q != StIdle);

   always_comb begin
      timeout_err_d = timeout_err_q;
      overrun_err_d = overrun_err_q;
      if (err_clr) begin
         timeout_err_d = 1'b0;
         overrun_err_d = 1'b0;
      end
      if (timeout_hit) begin
         timeout_err_d = 1'b1;
      end
      if (overrun_hit) begin
         overrun_err_d = 1'b1;
      end
   end

   // ------------------------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= StIdle;
         idx_q         <= 2'd0;
         wd_q          <= '0;
         mask_q        <= 4'd0;
         timeout_err_q <= 1'b0;
         overrun_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         wd_q          <= wd_d;
         mask_q        <= mask_d;
         timeout_err_q <= timeout_err_d;
         overrun_err_q <= overrun_err_d;
      end
   end

   // ------------------------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------------------------
   always_comb begin
      cl_draw    = 4'd0;
      vga_x      = 8'd0;
      vga_y      = 7'd0;
      vga_colour = 3'd0;
      if (active) begin
         cl_draw = 4'b0001 << idx_q;
         unique case (idx_q)
            2'd0: begin
               vga_x      = cl_x[7:0];
               vga_y      = cl_y[6:0];
               vga_colour = cl_colour[2:0];
            end
            2'd1: begin
               vga_x      = cl_x[15:8];
               vga_y      = cl_y[13:7];
               vga_colour = cl_colour[5:3];
            end
            2'd2: begin
               vga_x      = cl_x[23:16];
               vga_y      = cl_y[20:14];
               vga_colour = cl_colour[8:6];
            end
            default: begin
               vga_x      = cl_x[31:24];
               vga_y      = cl_y[27:21];
               vga_colour = cl_colour[11:9];
            end
         endcase
      end
   end

   // Plot stays high on the done cycle so the client's last pixel is written.
   assign plot        = active && wd_nz;
   // The tick-acceptance cycle counts as busy; gated so reset and abort win.
   assign busy        = (state_q != StIdle) || (frame_tick && reset && !space_pressed);
   assign frame_done  = (state_q == StFinish);
   assign timeout_err = timeout_err_q;
   assign overrun_err = overrun_err_q;

endmodule

// File: tb/tb_draw_scheduler.sv
// ---------------------------------------------------------------------------------------------
// Directed bench for draw_scheduler. Inputs change 1 time unit after the rising edge; outputs
// are sampled 2 units after the edge.
// ---------------------------------------------------------------------------------------------
module tb_draw_scheduler;

   logic        clk = 1'b0;
   logic        reset;
   logic        space_pressed;
   logic        frame_tick;
   logic [3:0]  enable_mask;
   logic        err_clr;
   logic [3:0]  cl_done;
   logic [31:0] cl_x;
   logic [27:0] cl_y;
   logic [11:0] cl_colour;
   logic [3:0]  cl_draw;
   logic [7:0]  vga_x;
   logic [6:0]  vga_y;
   logic [2:0]  vga_colour;
   logic        plot;
   logic        busy;
   logic        frame_done;
   logic        timeout_err;
   logic        overrun_err;

   always #5 clk = ~clk;

   draw_scheduler #(
      .TIMEOUT(255),
      .WD_W   (8)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .space_pressed(space_pressed),
      .frame_tick   (frame_tick),
      .enable_mask  (enable_mask),
      .err_clr      (err_clr),
      .cl_done      (cl_done),
      .cl_x         (cl_x),
      .cl_y         (cl_y),
      .cl_colour    (cl_colour),
      .cl_draw      (cl_draw),
      .vga_x        (vga_x),
      .vga_y        (vga_y),
      .vga_colour   (vga_colour),
      .plot         (plot),
      .busy         (busy),
      .frame_done   (frame_done),
      .timeout_err  (timeout_err),
      .overrun_err  (overrun_err)
   );

   int checks   = 0;
   int failures = 0;

   // Per-pass statistics gathered by run_pass.
   int          grant_cyc[4];
   int          plot_cyc[4];
   int          fd_cnt;
   int          busy_cnt;
   int          multi_cnt;
   int          vga_bad;
   int          stray_cnt;
   logic [15:0] order_log;
   logic [3:0]  prev_draw;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int oh_idx(input logic [3:0] v);
      case (v)
         4'b0001: return 0;
         4'b0010: return 1;
         4'b0100: return 2;
         default: return 3;
      endcase
   endfunction

   // Runs one pass from IDLE. dN is the watchdog value at which client N raises done
   // (-1 = never); stale0 also raises client 0 done on its grant-entry cycle; tick_wd0
   // injects a frame_tick (and a new enable_mask) at that wd of client 0 (-1 = none).
   task automatic run_pass(input logic [3:0] m, input int d0, input int d1, input int d2,
                           input int d3, input bit stale0, input int tick_wd0,
                           input int max_cyc);
      int  n;
      int  c;
      int  wd_est;
      int  dn[4];
      bit  finished;
      dn[0] = d0; dn[1] = d1; dn[2] = d2; dn[3] = d3;
      for (int i = 0; i < 4; i++) begin
         grant_cyc[i] = 0;
         plot_cyc[i]  = 0;
      end
      fd_cnt = 0; busy_cnt = 0; multi_cnt = 0; vga_bad = 0; stray_cnt = 0;
      order_log = 16'd0; prev_draw = 4'd0;
      frame_tick  = 1'b1;
      enable_mask = m;
      n = 0;
      finished = 1'b0;
      while (!finished && n < max_cyc) begin
         #1;
         if (frame_done) fd_cnt++;
         if (!busy && fd_cnt > 0) begin
            finished = 1'b1;
         end else begin
            if (busy) busy_cnt++;
            cl_done = 4'd0;
            if ($countones(cl_draw) > 1) begin
               multi_cnt++;
            end else if (cl_draw != 4'd0) begin
               c = oh_idx(cl_draw);
               wd_est = grant_cyc[c];
               grant_cyc[c]++;
               if (plot) plot_cyc[c]++;
               if (vga_x !== 8'((c + 1) * 17) || vga_y !== 7'((c + 1) * 10) ||
                   vga_colour !== 3'(c + 1)) vga_bad++;
               if (cl_draw != prev_draw) order_log = {order_log[11:0], 4'(c + 1)};
               if (wd_est == dn[c] || (stale0 && c == 0 && wd_est == 0)) cl_done[c] = 1'b1;
               if (c == 0 && wd_est == tick_wd0) begin
                  frame_tick  = 1'b1;
                  enable_mask = 4'b1111;
               end
            end else if (plot || vga_x != 8'd0 || vga_y != 7'd0 || vga_colour != 3'd0) begin
               stray_cnt++;
            end
            prev_draw = cl_draw;
            tick();
            frame_tick = 1'b0;
            n++;
         end
      end
      cl_done = 4'd0;
      if (!finished) begin
         checks++;
         failures++;
         $error("FAIL pass_bound observed=%0d expected=<%0d cycles", n, max_cyc);
      end
   endtask

   initial begin
      reset = 1'b0; space_pressed = 1'b0; frame_tick = 1'b0; enable_mask = 4'd0;
      err_clr = 1'b0; cl_done = 4'd0;
      cl_x      = 32'h4433_2211;
      cl_y      = {7'd40, 7'd30, 7'd20, 7'd10};
      cl_colour = {3'd4, 3'd3, 3'd2, 3'd1};
      tick();
      tick();
      reset = 1'b1;
      #1;
      chk("rst_cl_draw", 32'(cl_draw), 0);
      chk("rst_plot", 32'(plot), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_frame_done", 32'(frame_done), 0);
      chk("rst_errs", {30'd0, timeout_err, overrun_err}, 0);
      chk("rst_vga", {14'd0, vga_x, vga_y, vga_colour}, 0);
      tick();

      // Two clients, done at wd 16 and 20.
      run_pass(4'b0101, 16, -1, 20, -1, 1'b0, -1, 200);
      chk("p0101_grant0", grant_cyc[0], 17);
      chk("p0101_grant2", grant_cyc[2], 21);
      chk("p0101_plot0", plot_cyc[0], 16);
      chk("p0101_plot2", plot_cyc[2], 20);
      chk("p0101_order", 32'(order_log), 32'h13);
      chk("p0101_busy", busy_cnt, 46);
      chk("p0101_fd", fd_cnt, 1);
      chk("p0101_onehot", multi_cnt, 0);
      chk("p0101_vga", vga_bad, 0);
      chk("p0101_stray", stray_cnt, 0);
      chk("p0101_errs", {30'd0, timeout_err, overrun_err}, 0);

      // Empty mask.
      run_pass(4'b0000, -1, -1, -1, -1, 1'b0, -1, 50);
      chk("p0000_busy", busy_cnt, 6);
      chk("p0000_grants", grant_cyc[0] + grant_cyc[1] + grant_cyc[2] + grant_cyc[3], 0);
      chk("p0000_fd", fd_cnt, 1);

      // Watchdog release of client 1.
      run_pass(4'b0010, -1, -1, -1, -1, 1'b0, -1, 400);
      chk("pto_grant1", grant_cyc[1], 256);
      chk("pto_plot1", plot_cyc[1], 255);
      chk("pto_busy", busy_cnt, 263);
      chk("pto_fd", fd_cnt, 1);
      chk("pto_timeout_err", 32'(timeout_err), 1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      #1;
      chk("pto_err_clr", 32'(timeout_err), 0);

      // Done at wd = TIMEOUT wins over the watchdog.
      run_pass(4'b0100, -1, -1, 255, -1, 1'b0, -1, 400);
      chk("pdw_grant2", grant_cyc[2], 256);
      chk("pdw_timeout_err", 32'(timeout_err), 0);

      // Overrun tick plus new mask mid-grant: pass unchanged.
      run_pass(4'b0101, 16, -1, 20, -1, 1'b0, 3, 200);
      chk("pov_overrun", 32'(overrun_err), 1);
      chk("pov_order", 32'(order_log), 32'h13);
      chk("pov_grant0", grant_cyc[0], 17);
      chk("pov_grant2", grant_cyc[2], 21);
      chk("pov_busy", busy_cnt, 46);
      chk("pov_fd", fd_cnt, 1);

      // Set beats clear in the same cycle, then clear alone.
      frame_tick = 1'b1; enable_mask = 4'b0000;
      tick();
      err_clr = 1'b1;
      tick();
      frame_tick = 1'b0;
      #1;
      chk("err_set_wins", 32'(overrun_err), 1);
      tick();
      err_clr = 1'b0;
      #1;
      chk("err_clr_overrun", 32'(overrun_err), 0);
      for (int i = 0; i < 10 && busy; i++) tick();
      chk("idle_after_clr", 32'(busy), 0);

      // Stale done at grant entry is ignored.
      run_pass(4'b0001, 5, -1, -1, -1, 1'b1, -1, 50);
      chk("pst_grant0", grant_cyc[0], 6);
      chk("pst_plot0", plot_cyc[0], 5);
      chk("pst_busy", busy_cnt, 13);

      // Abort mid-grant of client 3.
      frame_tick = 1'b1; enable_mask = 4'b1000;
      tick();
      frame_tick = 1'b0;
      for (int i = 0; i < 10 && cl_draw != 4'b1000; i++) tick();
      chk("sp_granted", 32'(cl_draw), 32'b1000);
      tick();
      frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
      #1;
      chk("sp_overrun", 32'(overrun_err), 1);
      chk("sp_still_granted", 32'(cl_draw), 32'b1000);
      space_pressed = 1'b1;
      tick();
      space_pressed = 1'b0;
      #1;
      chk("sp_cl_draw", 32'(cl_draw), 0);
      chk("sp_plot", 32'(plot), 0);
      chk("sp_busy", 32'(busy), 0);
      fd_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         if (frame_done) fd_cnt++;
         tick();
      end
      chk("sp_no_fd", fd_cnt, 0);
      chk("sp_sticky_kept", 32'(overrun_err), 1);
      reset = 1'b0; frame_tick = 1'b1; space_pressed = 1'b1; err_clr = 1'b0;
      tick();
      #1;
      chk("sp_rst_busy", 32'(busy), 0);
      chk("sp_rst_errs", {30'd0, timeout_err, overrun_err}, 0);
      reset = 1'b1; frame_tick = 1'b0; space_pressed = 1'b0;
      tick();

      // Reset mid-grant outranks a simultaneous tick.
      frame_tick = 1'b1; enable_mask = 4'b0001;
      tick();
      frame_tick = 1'b0;
      tick();
      tick();
      #1;
      chk("rm_granted", 32'(cl_draw), 32'b0001);
      reset = 1'b0; frame_tick = 1'b1; err_clr = 1'b1;
      tick();
      #1;
      chk("rm_cl_draw", 32'(cl_draw), 0);
      chk("rm_plot", 32'(plot), 0);
      chk("rm_busy", 32'(busy), 0);
      chk("rm_frame_done", 32'(frame_done), 0);
      chk("rm_errs", {30'd0, timeout_err, overrun_err}, 0);
      chk("rm_vga", {14'd0, vga_x, vga_y, vga_colour}, 0);
      reset = 1'b1; frame_tick = 1'b0; err_clr = 1'b0;
      tick();
      #1;
      chk("rm_idle", 32'(busy), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
